// File: rtl/ysyx_22050019_lsu_axi_pkg.sv
// Shared types and helpers for the AXI4-Lite load/store unit.
// Misaligned-access trapping is built in only when YSYX_22050019_LSU_MISALIGN_CHK_EN is defined.
package ysyx_22050019_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // funct3[1:0] encodes log2(bytes) for both loads and stores
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_axi_if.sv
// AXI4-Lite bus between the LSU (master) and memory/peripheral fabric (slave).
interface ysyx_22050019_lsu_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/ysyx_22050019_lsu_align.sv
// Combinational lane steering: store data/strobe shift-up and load shift-down plus extension.
module ysyx_22050019_lsu_align
  import ysyx_22050019_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8,
  parameter int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  i_st_off,
  input  logic [2:0]        i_st_funct3,
  input  logic [DATA_W-1:0] i_st_data,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [OFF_W-1:0]  i_ld_off,
  input  logic [2:0]        i_ld_funct3,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [STRB_W+7:0] w_mask;
  logic [DATA_W-1:0] w_sh;

  always_comb begin
    // lanes pushed past the top of the bus are simply dropped
    w_mask  = (STRB_W+8)'(size_mask(i_st_funct3[1:0])) << i_st_off;
    o_wstrb = w_mask[STRB_W-1:0];
    o_wdata = i_st_data << {i_st_off, 3'b000};

    w_sh      = i_ld_data >> {i_ld_off, 3'b000};
    o_ld_data = w_sh;
    case (i_ld_funct3)
      F3_LB:  o_ld_data = {{(DATA_W-8){w_sh[7]}},   w_sh[7:0]};
      F3_LH:  o_ld_data = {{(DATA_W-16){w_sh[15]}}, w_sh[15:0]};
      F3_LW:  o_ld_data = {{(DATA_W-32){w_sh[31]}}, w_sh[31:0]};
      F3_LD:  o_ld_data = w_sh;
      F3_LBU: o_ld_data = {{(DATA_W-8){1'b0}},  w_sh[7:0]};
      F3_LHU: o_ld_data = {{(DATA_W-16){1'b0}}, w_sh[15:0]};
      F3_LWU: o_ld_data = {{(DATA_W-32){1'b0}}, w_sh[31:0]};
      default: o_ld_data = w_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22050019_lsu_axi.sv
// MEM-stage load/store unit: one AXI4-Lite transaction per request, stalls the pipe meanwhile.
// Define YSYX_22050019_LSU_MISALIGN_CHK_EN to trap misaligned accesses instead of issuing them.
module ysyx_22050019_lsu_axi
  import ysyx_22050019_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_stall_req,
  output logic              lsu_bus_err,
  output logic              lsu_misalign,
  ysyx_22050019_lsu_axi_if.master axi
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;

  logic [STRB_W-1:0] w_st_strb;
  logic [DATA_W-1:0] w_st_data;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_mis, w_req, w_idle, w_rd_done, w_wr_done, w_done;
  logic              w_aw_fin, w_w_fin;

  ysyx_22050019_lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_st_off    (mem_addr[OFF_W-1:0]),
    .i_st_funct3 (mem_funct3),
    .i_st_data   (mem_wdata),
    .o_wstrb     (w_st_strb),
    .o_wdata     (w_st_data),
    .i_ld_off    (r_addr[OFF_W-1:0]),
    .i_ld_funct3 (r_funct3),
    .i_ld_data   (axi.rdata),
    .o_ld_data   (w_ld_data)
  );

`ifdef YSYX_22050019_LSU_MISALIGN_CHK_EN
  assign w_mis = (mem_ren | mem_wen) & is_misaligned(mem_addr[2:0], mem_funct3[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_idle    = (r_state == S_IDLE);
  assign w_req     = (mem_ren | mem_wen) & ~w_mis;
  assign w_rd_done = (r_state == S_RD_DATA) & axi.rvalid;
  assign w_wr_done = (r_state == S_WR_RESP) & axi.bvalid;
  assign w_done    = w_rd_done | w_wr_done;
  // a channel is finished once its valid has dropped or it handshakes this cycle
  assign w_aw_fin  = ~r_awvalid | axi.awready;
  assign w_w_fin   = ~r_wvalid  | axi.wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_funct3  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_addr   <= mem_addr;
          r_funct3 <= mem_funct3;
          r_wdata  <= w_st_data;
          r_wstrb  <= w_st_strb;
          if (mem_ren) begin
            r_state   <= S_RD_ADDR;
            r_arvalid <= 1'b1;
          end else begin
            r_state   <= S_WR_REQ;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        S_RD_ADDR: if (axi.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= S_RD_DATA;
        end
        S_RD_DATA: if (axi.rvalid) begin
          r_rready <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_WR_REQ: begin
          if (axi.awready) r_awvalid <= 1'b0;
          if (axi.wready)  r_wvalid  <= 1'b0;
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: if (axi.bvalid) begin
          r_bready <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign axi.araddr  = r_addr;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;
  assign axi.awaddr  = r_addr;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;

  // rst_n gating keeps the combinational outputs quiet while held in reset
  assign lsu_stall_req = rst_n & ((w_idle & w_req) | (~w_idle & ~w_done));
  assign lsu_rdata     = w_rd_done ? w_ld_data : '0;
  assign lsu_bus_err   = (w_rd_done & (axi.rresp != RESP_OKAY)) |
                         (w_wr_done & (axi.bresp != RESP_OKAY));
  assign lsu_misalign  = rst_n & w_idle & w_mis;

endmodule

// File: tb/tb_ysyx_22050019_lsu_axi.sv
// Directed bench for the AXI4-Lite LSU with a scoreboard of expected load data / store beats.
module tb_ysyx_22050019_lsu_axi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren = 1'b0, mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [63:0] lsu_rdata;
  logic        lsu_stall_req, lsu_bus_err, lsu_misalign;

  int checks = 0;
  int failures = 0;

  logic [63:0] q_rd[$];
  logic [71:0] q_wr[$];

  ysyx_22050019_lsu_axi_if #(.ADDR_W(32), .DATA_W(64)) axi ();

  ysyx_22050019_lsu_axi #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_funct3   (mem_funct3),
    .lsu_rdata    (lsu_rdata),
    .lsu_stall_req(lsu_stall_req),
    .lsu_bus_err  (lsu_bus_err),
    .lsu_misalign (lsu_misalign),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stall"}, 64'(lsu_stall_req), 64'd0);
    chk({tag, "_busv"}, {59'd0, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 64'd0);
    chk({tag, "_rdata"}, lsu_rdata, 64'd0);
    chk({tag, "_err"}, 64'(lsu_bus_err), 64'd0);
  endtask

  task automatic pop_rd(input string tag);
    if (q_rd.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else chk(tag, lsu_rdata, q_rd.pop_front());
  endtask

  task automatic pop_wr(input string tag);
    if (q_wr.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      logic [71:0] e;
      e = q_wr.pop_front();
      chk({tag, "_strb"}, 64'(axi.wstrb), 64'(e[71:64]));
      chk({tag, "_data"}, axi.wdata, e[63:0]);
    end
  endtask

  // zero-wait-state load: request, AR handshake, R handshake
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [63:0] rd,
                         input logic [1:0] rsp, input logic [63:0] exp);
    q_rd.push_back(exp);
    @(negedge clk); mem_ren = 1'b1; mem_addr = a; mem_funct3 = f3;
    #1 chk("ld_req_stall", 64'(lsu_stall_req), 64'd1);
    chk("ld_req_noar", 64'(axi.arvalid), 64'd0);
    @(negedge clk); axi.arready = 1'b1;
    #1 chk("ld_ar_valid", 64'(axi.arvalid), 64'd1);
    chk("ld_araddr", 64'(axi.araddr), 64'(a));
    chk("ld_ar_stall", 64'(lsu_stall_req), 64'd1);
    @(negedge clk); axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = rd; axi.rresp = rsp;
    #1 chk("ld_rready", 64'(axi.rready), 64'd1);
    chk("ld_done_stall", 64'(lsu_stall_req), 64'd0);
    chk("ld_err", 64'(lsu_bus_err), 64'(rsp != 2'b00));
    pop_rd("ld_rdata");
    @(negedge clk); axi.rvalid = 1'b0; mem_ren = 1'b0;
    #1 chk_idle("ld_after");
  endtask

  // zero-wait-state store: request, AW+W handshake together, B handshake
  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [63:0] d,
                          input logic [7:0] es, input logic [63:0] ed, input logic [1:0] rsp);
    q_wr.push_back({es, ed});
    @(negedge clk); mem_wen = 1'b1; mem_addr = a; mem_funct3 = f3; mem_wdata = d;
    #1 chk("st_req_stall", 64'(lsu_stall_req), 64'd1);
    @(negedge clk); axi.awready = 1'b1; axi.wready = 1'b1;
    #1 chk("st_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
    chk("st_awaddr", 64'(axi.awaddr), 64'(a));
    chk("st_aw_stall", 64'(lsu_stall_req), 64'd1);
    pop_wr("st_beat");
    @(negedge clk); axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = rsp;
    #1 chk("st_bready", 64'(axi.bready), 64'd1);
    chk("st_done_stall", 64'(lsu_stall_req), 64'd0);
    chk("st_err", 64'(lsu_bus_err), 64'(rsp != 2'b00));
    @(negedge clk); axi.bvalid = 1'b0; mem_wen = 1'b0;
    #1 chk_idle("st_after");
  endtask

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;

    #1 chk_idle("reset");
    chk("reset_mis", 64'(lsu_misalign), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    // quiet pipe: no stall, no bus traffic
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk_idle("no_req");
    end

    do_load(32'h8000_0008, 3'b011, 64'h1122334455667788, 2'b00, 64'h1122334455667788);
    do_load(32'h8000_0003, 3'b000, 64'h0000000080000000, 2'b00, 64'hFFFFFFFFFFFFFF80);
    do_load(32'h8000_0003, 3'b100, 64'h0000000080000000, 2'b00, 64'h0000000000000080);
    do_load(32'h8000_0004, 3'b110, 64'hF000000012345678, 2'b00, 64'h00000000F0000000);
    do_load(32'h8000_0006, 3'b001, 64'h8001000000000000, 2'b10, 64'hFFFFFFFFFFFF8001);

    do_store(32'h8000_0006, 3'b001, 64'h000000000000BEEF, 8'hC0, 64'hBEEF000000000000, 2'b00);
    do_store(32'h8000_0000, 3'b011, 64'h0102030405060708, 8'hFF, 64'h0102030405060708, 2'b00);
    do_store(32'h8000_0005, 3'b000, 64'h00000000000000AB, 8'h20, 64'h0000AB0000000000, 2'b10);

    // W handshakes first, AW three cycles later; one B closes it
    q_wr.push_back({8'h0F, 64'h00000000CAFEF00D});
    @(negedge clk); mem_wen = 1'b1; mem_addr = 32'h8000_0010; mem_funct3 = 3'b010;
    mem_wdata = 64'h00000000CAFEF00D;
    @(negedge clk); axi.wready = 1'b1;
    #1 pop_wr("split_beat");
    @(negedge clk); axi.wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("split_w_dropped", {62'd0, axi.awvalid, axi.wvalid}, 64'd2);
      chk("split_stall", 64'(lsu_stall_req), 64'd1);
      @(negedge clk);
    end
    axi.awready = 1'b1;
    #1 chk("split_aw_hs", {62'd0, axi.awvalid, axi.bready}, 64'd2);
    @(negedge clk); axi.awready = 1'b0;
    #1 chk("split_bwait", {61'd0, axi.awvalid, axi.bready, lsu_stall_req}, 64'd3);
    @(negedge clk); axi.bvalid = 1'b1; axi.bresp = 2'b00;
    #1 chk("split_b_stall", 64'(lsu_stall_req), 64'd0);
    @(negedge clk); axi.bvalid = 1'b0; mem_wen = 1'b0;
    #1 chk_idle("split_after");

    // reset while waiting on R abandons the load
    @(negedge clk); mem_ren = 1'b1; mem_addr = 32'h8000_0020; mem_funct3 = 3'b010;
    @(negedge clk); axi.arready = 1'b1;
    @(negedge clk); axi.arready = 1'b0;
    #1 chk("rst_in_rdata", 64'(axi.rready), 64'd1);
    rst_n = 1'b0;
    #1 chk_idle("rst_mid");
    @(negedge clk); mem_ren = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_load(32'h8000_0004, 3'b010, 64'h89ABCDEF01234567, 2'b00, 64'hFFFFFFFF89ABCDEF);

`ifdef YSYX_22050019_LSU_MISALIGN_CHK_EN
    @(negedge clk); mem_ren = 1'b1; mem_addr = 32'h8000_0002; mem_funct3 = 3'b010;
    #1 chk("mis_flag", 64'(lsu_misalign), 64'd1);
    chk("mis_stall", 64'(lsu_stall_req), 64'd0);
    @(negedge clk); mem_ren = 1'b0;
    #1 chk_idle("mis_after");
    chk("mis_flag_drop", 64'(lsu_misalign), 64'd0);
`else
    do_load(32'h8000_0002, 3'b010, 64'h1122334455667788, 2'b00, 64'h0000000033445566);
    do_store(32'h8000_0006, 3'b010, 64'h00000000DEADBEEF, 8'hC0, 64'hBEEF000000000000, 2'b00);
    chk("mis_tied", 64'(lsu_misalign), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
